seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//  Parametrised, handshaked successor to the 16-bit combinational ALU of the SIMPLE core.
//  Generalised to WIDTH bits, with registered results and a defined V/Z/C/S flag set:
//   - V: signed overflow. C: carry/borrow or shifted-out bit.
//  Adds an arithmetic right shift and an iterative unsigned multiply (shift-add, one bit per cycle).
//  Sits between the register-read stage and writeback; the EX stage stalls on in_ready/out_valid.
// PARAMETERS
//  WIDTH    16               datapath width in bits (>=4)
//  SHAMT_W  $clog2(WIDTH)    width of the counter in the MUL state (holds 0..WIDTH-1)
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      operands/opcode valid
//  in_ready   out  1      block can accept an operation
//  opcode     in   4      0 ADD, 1 SUB, 2 MUL, 8 AND, 9 OR, 10 SLL, 11 SRL, 12 SRA; others -> NOP
//  in1        in   WIDTH  operand A
//  in2        in   WIDTH  operand B (full width is the shift amount)
//  out_valid  out  1      result/flags valid; held until accepted
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  registered result
//  v,z,c,s    out  1      registered flags for the result
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; result, v, z, c and s are 0; out_valid=0; in_ready=1.
//  Reset mid-MUL aborts the operation; no result is produced.
//  FSM states: IDLE, MUL, DONE.
//   - IDLE: in_ready=1. On in_valid with a non-MUL opcode: compute, register, go to DONE.
//   - IDLE: on in_valid with opcode 2: latch operands, clear the 2*WIDTH accumulator and counter, go to MUL.
//   - MUL: in_ready=0. Each cycle: if multiplier bit[0]=1, add the shifted multiplicand to acc;
//     shift the multiplicand left and the multiplier right.
//     After WIDTH iterations, register acc[WIDTH-1:0] and go to DONE.
//   - DONE: out_valid=1 and in_ready=0; outputs stable. On out_ready go to IDLE
//     (out_valid drops on the next cycle).
//  Latency: non-MUL -> out_valid the cycle after acceptance. MUL -> out_valid WIDTH+1 cycles after acceptance.
//  Throughput: at most one operation per two cycles (no accept while DONE).
//  in_valid is ignored outside IDLE; operands are sampled only on the accept edge.
//  Arithmetic uses WIDTH+1-bit internal sums. Flags per opcode:
//   - ADD: c = carry-out. v = (a[W-1]==b[W-1]) && (r[W-1]!=a[W-1]).
//   - SUB: r = a-b. c = borrow (a<b unsigned). v = (a[W-1]!=b[W-1]) && (r[W-1]!=a[W-1]).
//   - MUL: r = low WIDTH bits of the unsigned product; v = (upper WIDTH bits != 0); c = 0.
//   - AND/OR: v = 0, c = 0.
//   - SLL/SRL: shift by in2. If in2 >= WIDTH: r = 0, c = 0. If in2 == 0: c = 0.
//     Otherwise c = the last bit shifted out. v = 0.
//   - SRA: sign fill. If in2 >= WIDTH: r = {WIDTH{a[W-1]}}, c = a[W-1]. Otherwise c as for SRL. v = 0.
//   - NOP (undefined opcode): r = 0; completes with latency 1.
//  All opcodes: z = (r == 0) over the full WIDTH; s = r[WIDTH-1].
// TESTING (WIDTH=16)
//  1. ADD 0x7FFF+0x0001 -> out_valid next cycle; r=0x8000, v=1, c=0, s=1, z=0.
//  2. SUB 0x0003-0x0005 -> r=0xFFFE, c=1, v=0, s=1.
//     SUB 0x8000-0x0001 -> r=0x7FFF, v=1.
//  3. MUL 0x0123*0x0045 -> in_ready=0 for 16 cycles; out_valid on cycle 17; r=0x4E6F, v=0.
//     MUL 0x1000*0x0010 -> r=0x0000, z=1, v=1.
//  4. SRA 0x8001 by 1 -> r=0xC000, c=1. SRA 0x8000 by 20 -> r=0xFFFF, c=1.
//     SLL 0x8001 by 16 -> r=0, z=1, c=0.
//  5. Backpressure: hold out_ready=0 for 5 cycles after ADD 2+3.
//     r=5 and out_valid stay stable; a second in_valid is not accepted until one cycle after out_ready.
//  6. Assert reset 7 cycles into a MUL -> all outputs 0, in_ready=1.
//     Then ADD 1+1 -> r=2 with normal latency.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked WIDTH-bit ALU with registered result and V/Z/C/S flags.
// Single-cycle ops finish in one cycle; MUL is iterative shift-add, one multiplier bit per cycle.
module seq_alu #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             v,
  output logic             z,
  output logic             c,
  output logic             s
);

  localparam int unsigned AW = 2 * WIDTH;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;
  localparam logic [3:0] OP_SLL = 4'd10;
  localparam logic [3:0] OP_SRL = 4'd11;
  localparam logic [3:0] OP_SRA = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_v, r_z, r_c, r_s;
  logic [AW-1:0]      r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [AW-1:0]      r_acc;
  logic [SHAMT_W-1:0] r_cnt;

  logic                    w_accept;
  logic                    w_mul_last;
  logic [AW-1:0]           w_acc_nxt;
  logic [WIDTH:0]          w_sum;
  logic [WIDTH:0]          w_diff;
  logic                    w_big;
  logic [SHAMT_W-1:0]      w_sh;
  logic [WIDTH:0]          w_sll;
  logic [WIDTH:0]          w_srl;
  logic signed [WIDTH:0]   w_sra;
  logic [WIDTH-1:0]        w_alu_res;
  logic                    w_alu_v;
  logic                    w_alu_c;

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_mul_last = (r_state == S_MUL) && (r_cnt == SHAMT_W'(WIDTH - 1));
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : AW'(0));

  // Extended shifts: the extra bit catches the last bit shifted out.
  assign w_sum  = {1'b0, in1} + {1'b0, in2};
  assign w_diff = {1'b0, in1} - {1'b0, in2};
  assign w_big  = (in2 >= WIDTH'(WIDTH));
  assign w_sh   = in2[SHAMT_W-1:0];
  assign w_sll  = {1'b0, in1} << w_sh;
  assign w_srl  = {in1, 1'b0} >> w_sh;
  assign w_sra  = $signed({in1, 1'b0}) >>> w_sh;

  // Next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = (opcode == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (w_mul_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle operations.
  always_comb begin
    w_alu_res = '0;
    w_alu_v   = 1'b0;
    w_alu_c   = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_c   = w_diff[WIDTH];
        w_alu_v   = (in1[WIDTH-1] != in2[WIDTH-1]) && (w_diff[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND: w_alu_res = in1 & in2;
      OP_OR:  w_alu_res = in1 | in2;
      OP_SLL: if (!w_big) begin
        w_alu_res = w_sll[WIDTH-1:0];
        w_alu_c   = w_sll[WIDTH];
      end
      OP_SRL: if (!w_big) begin
        w_alu_res = w_srl[WIDTH:1];
        w_alu_c   = w_srl[0];
      end
      OP_SRA: begin
        if (w_big) begin
          w_alu_res = {WIDTH{in1[WIDTH-1]}};
          w_alu_c   = in1[WIDTH-1];
        end else begin
          w_alu_res = w_sra[WIDTH:1];
          w_alu_c   = w_sra[0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_v      <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_s      <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_accept && (opcode == OP_MUL)) begin
        r_mcand  <= {WIDTH'(0), in1};
        r_mplier <= in2;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + SHAMT_W'(1);
      end
      if (w_accept && (opcode != OP_MUL)) begin
        r_result <= w_alu_res;
        r_v      <= w_alu_v;
        r_c      <= w_alu_c;
        r_z      <= (w_alu_res == '0);
        r_s      <= w_alu_res[WIDTH-1];
      end else if (w_mul_last) begin
        r_result <= w_acc_nxt[WIDTH-1:0];
        r_v      <= |w_acc_nxt[AW-1:WIDTH];
        r_c      <= 1'b0;
        r_z      <= (w_acc_nxt[WIDTH-1:0] == '0);
        r_s      <= w_acc_nxt[WIDTH-1];
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign v         = r_v;
  assign z         = r_z;
  assign c         = r_c;
  assign s         = r_s;

endmodule
